// File: rtl/channel_run_ctrl.sv
// PAM-4 channel run controller: issues N mapped symbols to a channel model, waits for the
// channel to echo them (or times out), then pulses done.

module channel_run_ctrl #(
  parameter int SIGNAL_RESOLUTION = 8,
  parameter int SYMBOL_SEPERATION = 56,
  parameter int CNT_WIDTH         = 16,
  parameter int DRAIN_TIMEOUT     = 8
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                start,
  input  logic [CNT_WIDTH-1:0]                num_symbols,
  input  logic                                abort,
  input  logic [1:0]                          src_symbol,
  input  logic                                src_valid,
  output logic                                src_ready,
  output logic signed [SIGNAL_RESOLUTION-1:0] chan_signal_in,
  output logic                                chan_in_valid,
  input  logic                                chan_out_valid,
  output logic                                busy,
  output logic                                done,
  output logic                                timeout,
  output logic [CNT_WIDTH-1:0]                sent_count,
  output logic [CNT_WIDTH-1:0]                recv_count
);

  // Level math needs headroom for 3 * SYMBOL_SEPERATION before saturation.
  localparam int AW = (SIGNAL_RESOLUTION + 2 > 34) ? SIGNAL_RESOLUTION + 2 : 34;
  localparam int DW = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic signed [AW-1:0] SepW   = AW'(SYMBOL_SEPERATION);
  localparam logic signed [AW-1:0] Two    = AW'(2);
  localparam logic signed [AW-1:0] Three  = AW'(3);
  localparam logic signed [AW-1:0] LvlMax = (AW'(1) <<< (SIGNAL_RESOLUTION - 1)) - AW'(1);
  localparam logic signed [AW-1:0] LvlMin = -LvlMax - AW'(1);
  localparam logic [DW-1:0]        DrainLast = DW'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CntOne    = CNT_WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                         state_q;
  logic [CNT_WIDTH-1:0]           n_q;
  logic [DW-1:0]                  drain_cnt_q;
  logic                           accept;
  logic                           recv_inc;
  logic signed [AW-1:0]           sym_w;
  logic signed [AW-1:0]           level_w;
  logic signed [SIGNAL_RESOLUTION-1:0] level_sat;

  always_comb begin
    src_ready = (state_q == StRun) && (sent_count < n_q) && !abort;
    accept    = src_ready && src_valid;
    recv_inc  = chan_out_valid && ((state_q == StRun) || (state_q == StDrain)) &&
                (recv_count != '1);
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
  end

  always_comb begin
    sym_w   = $signed({{(AW-2){1'b0}}, src_symbol});
    level_w = ((sym_w <<< 1) - Three) * SepW / Two;
    if (level_w > LvlMax) begin
      level_sat = LvlMax[SIGNAL_RESOLUTION-1:0];
    end else if (level_w < LvlMin) begin
      level_sat = LvlMin[SIGNAL_RESOLUTION-1:0];
    end else begin
      level_sat = level_w[SIGNAL_RESOLUTION-1:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= StIdle;
      n_q            <= '0;
      drain_cnt_q    <= '0;
      chan_signal_in <= '0;
      chan_in_valid  <= 1'b0;
      timeout        <= 1'b0;
      sent_count     <= '0;
      recv_count     <= '0;
    end else begin
      chan_in_valid <= accept;
      if (accept) begin
        chan_signal_in <= level_sat;
        sent_count     <= sent_count + CntOne;
      end
      if (recv_inc) begin
        recv_count <= recv_count + CntOne;
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            n_q        <= num_symbols;
            sent_count <= '0;
            recv_count <= '0;
            timeout    <= 1'b0;
            state_q    <= (num_symbols == '0) ? StDone : StRun;
          end
        end
        StRun: begin
          drain_cnt_q <= '0;
          // abort already blocks src_ready, so a final accept can never be lost to it.
          if ((accept && (sent_count + CntOne == n_q)) || abort) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (recv_count == sent_count) begin
            state_q <= StDone;
          end else if (drain_cnt_q == DrainLast) begin
            timeout <= 1'b1;
            state_q <= StDone;
          end else begin
            drain_cnt_q <= drain_cnt_q + DW'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
